// File: rtl/uart_cmd_bridge.sv
// UART command bridge: assembles host frames from the RX FIFO, issues one register access, returns status/data.
// Optional inter-byte timeout enabled by defining UART_CMD_BRIDGE_TIMEOUT_EN.
module uart_cmd_bridge #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        CLK_I,
  input  logic        RST_NI,
  input  logic        UART_RX_EMPTY_I,
  output logic        UART_RE_O,
  input  logic [7:0]  UART_DREC_I,
  input  logic        UART_TX_READY_I,
  output logic        UART_WE_O,
  output logic [7:0]  UART_DSEND_O,
  output logic        REQ_VALID_O,
  input  logic        REQ_READY_I,
  output logic        REQ_WE_O,
  output logic [7:0]  REQ_ADDR_O,
  output logic [31:0] REQ_WDATA_O,
  input  logic        RSP_VALID_I,
  input  logic [31:0] RSP_RDATA_I,
  input  logic        RSP_ERR_I,
  output logic        BUSY_O
);

  typedef enum logic [2:0] {RX_CMD, RX_ADDR, RX_DATA, REQ, RSP, TX_BYTE, TX_GAP} state_t;

  state_t      state, state_nxt;
  logic        pop, pop_q, rx_state, tmo;
  logic        is_wr_q, we_q, req_vld_q;
  logic [7:0]  addr_q, status_q, dsend_q;
  logic [31:0] wdata_q, rdata_q;
  logic [2:0]  cnt_q, len_q;

  if (TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  function automatic logic [7:0] tx_sel(input logic [2:0] idx, input logic [7:0] status,
                                        input logic [31:0] rdata);
    case (idx)
      3'd1:    tx_sel = rdata[7:0];
      3'd2:    tx_sel = rdata[15:8];
      3'd3:    tx_sel = rdata[23:16];
      3'd4:    tx_sel = rdata[31:24];
      default: tx_sel = status;
    endcase
  endfunction

  // pop_q blocks back-to-back pops so the FIFO empty flag has a cycle to settle
  always_comb begin
    rx_state = (state == RX_CMD) || (state == RX_ADDR) || (state == RX_DATA);
    pop      = rx_state && !UART_RX_EMPTY_I && !pop_q;
    BUSY_O   = (state != RX_CMD);
  end

  assign UART_RE_O    = pop;
  assign UART_WE_O    = we_q;
  assign UART_DSEND_O = dsend_q;
  assign REQ_VALID_O  = req_vld_q;
  assign REQ_WE_O     = is_wr_q;
  assign REQ_ADDR_O   = addr_q;
  assign REQ_WDATA_O  = wdata_q;

`ifdef UART_CMD_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  assign tmo = (tmo_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI)
      tmo_q <= '0;
    else if ((state == RX_ADDR || state == RX_DATA) && !pop) begin
      if (!tmo) tmo_q <= tmo_q + TW'(1);
    end else
      tmo_q <= '0;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) state <= RX_CMD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_CMD:  if (pop) state_nxt = (UART_DREC_I == 8'h01 || UART_DREC_I == 8'h02) ? RX_ADDR : TX_BYTE;
      RX_ADDR: if (pop) state_nxt = is_wr_q ? RX_DATA : REQ;
               else if (tmo) state_nxt = RX_CMD;
      RX_DATA: if (pop) begin
                 if (cnt_q == 3'd3) state_nxt = REQ;
               end else if (tmo) state_nxt = RX_CMD;
      REQ:     if (REQ_READY_I) state_nxt = RSP;
      RSP:     if (RSP_VALID_I) state_nxt = TX_BYTE;
      TX_BYTE: if (UART_TX_READY_I) state_nxt = TX_GAP;
      TX_GAP:  state_nxt = (cnt_q < len_q) ? TX_BYTE : RX_CMD;
      default: state_nxt = RX_CMD;
    endcase
  end

  // request valid follows the next state, so it drops the cycle after the handshake
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      pop_q     <= 1'b0;
      we_q      <= 1'b0;
      req_vld_q <= 1'b0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= '0;
      dsend_q   <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
    end else begin
      pop_q     <= pop;
      we_q      <= 1'b0;
      req_vld_q <= (state_nxt == REQ);
      case (state)
        RX_CMD: if (pop) begin
          is_wr_q  <= (UART_DREC_I == 8'h02);
          status_q <= (UART_DREC_I == 8'h03) ? 8'h00 : 8'hEE;
          len_q    <= 3'd1;
          cnt_q    <= '0;
        end
        RX_ADDR: if (pop) begin
          addr_q <= UART_DREC_I;
          cnt_q  <= '0;
        end
        RX_DATA: if (pop) begin
          wdata_q[{cnt_q[1:0], 3'b000} +: 8] <= UART_DREC_I;
          cnt_q <= cnt_q + 3'd1;
        end
        RSP: if (RSP_VALID_I) begin
          rdata_q  <= RSP_RDATA_I;
          status_q <= {7'd0, RSP_ERR_I};
          len_q    <= (!is_wr_q && !RSP_ERR_I) ? 3'd5 : 3'd1;
          cnt_q    <= '0;
        end
        TX_BYTE: if (UART_TX_READY_I) begin
          we_q    <= 1'b1;
          dsend_q <= tx_sel(cnt_q, status_q, rdata_q);
          cnt_q   <= cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed scoreboard bench for uart_cmd_bridge: models the RX FIFO and the register responder.
module tb_uart_cmd_bridge;
  logic        CLK_I = 1'b0;
  logic        RST_NI;
  logic        UART_RX_EMPTY_I;
  logic        UART_RE_O;
  logic [7:0]  UART_DREC_I;
  logic        UART_TX_READY_I;
  logic        UART_WE_O;
  logic [7:0]  UART_DSEND_O;
  logic        REQ_VALID_O;
  logic        REQ_READY_I;
  logic        REQ_WE_O;
  logic [7:0]  REQ_ADDR_O;
  logic [31:0] REQ_WDATA_O;
  logic        RSP_VALID_I;
  logic [31:0] RSP_RDATA_I;
  logic        RSP_ERR_I;
  logic        BUSY_O;

  uart_cmd_bridge #(.TIMEOUT_CYCLES(50)) dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI),
    .UART_RX_EMPTY_I(UART_RX_EMPTY_I), .UART_RE_O(UART_RE_O), .UART_DREC_I(UART_DREC_I),
    .UART_TX_READY_I(UART_TX_READY_I), .UART_WE_O(UART_WE_O), .UART_DSEND_O(UART_DSEND_O),
    .REQ_VALID_O(REQ_VALID_O), .REQ_READY_I(REQ_READY_I), .REQ_WE_O(REQ_WE_O),
    .REQ_ADDR_O(REQ_ADDR_O), .REQ_WDATA_O(REQ_WDATA_O),
    .RSP_VALID_I(RSP_VALID_I), .RSP_RDATA_I(RSP_RDATA_I), .RSP_ERR_I(RSP_ERR_I),
    .BUSY_O(BUSY_O)
  );

  always #5 CLK_I = ~CLK_I;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rx_fifo[$];
  logic [7:0]  tx_exp[$];
  logic [40:0] req_exp[$];   // {we, addr, wdata}

  int          rsp_delay = 1;
  logic [31:0] rsp_rdata = '0;
  logic        rsp_err   = 1'b0;
  int          we_count  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] b[$]);
    foreach (b[i]) rx_fifo.push_back(b[i]);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      cyc(1);
      if (rx_fifo.size() == 0 && tx_exp.size() == 0 && req_exp.size() == 0 && !BUSY_O && !UART_WE_O)
        done = 1;
    end
    chk({tag, "_idle"}, done, 1'b1);
  endtask

  // RX FIFO model: pops on the edge where UART_RE_O was high, presents the new head after the edge
  initial begin
    logic re_s;
    UART_RX_EMPTY_I = 1'b1;
    UART_DREC_I     = 8'h00;
    forever begin
      @(negedge CLK_I);
      re_s = UART_RE_O;
      @(posedge CLK_I);
      #1;
      if (re_s && rx_fifo.size() > 0) void'(rx_fifo.pop_front());
      UART_RX_EMPTY_I = (rx_fifo.size() == 0);
      UART_DREC_I     = (rx_fifo.size() == 0) ? 8'h00 : rx_fifo[0];
    end
  end

  // Register responder: one-cycle response strobe rsp_delay cycles after each handshake
  initial begin
    int rsp_wait = 0;
    RSP_VALID_I = 1'b0;
    RSP_RDATA_I = '0;
    RSP_ERR_I   = 1'b0;
    forever begin
      @(negedge CLK_I);
      RSP_VALID_I = 1'b0;
      RSP_RDATA_I = $urandom;
      RSP_ERR_I   = 1'($urandom_range(1));
      if (rsp_wait > 0) begin
        rsp_wait--;
        if (rsp_wait == 0) begin
          RSP_VALID_I = 1'b1;
          RSP_RDATA_I = rsp_rdata;
          RSP_ERR_I   = rsp_err;
        end
      end
      if (REQ_VALID_O && REQ_READY_I) rsp_wait = rsp_delay;
    end
  end

  // Output monitor: TX bytes and requests against the scoreboard, plus protocol rules
  initial begin
    logic        re_prev = 1'b0, we_prev = 1'b0, vld_prev = 1'b0, rdy_prev = 1'b0;
    logic [40:0] req_prev = '0;
    logic [40:0] e;
    forever begin
      @(negedge CLK_I);
      if (UART_RE_O) chk("re_consecutive", re_prev, 1'b0);
      if (UART_WE_O) begin
        we_count++;
        chk("we_consecutive", we_prev, 1'b0);
        checks++;
        assert (tx_exp.size() != 0) else begin
          errors++;
          $error("FAIL tx_unexpected observed=%0h expected=none", UART_DSEND_O);
        end
        if (tx_exp.size() != 0) chk("tx_byte", UART_DSEND_O, tx_exp.pop_front());
      end
      if (vld_prev && !rdy_prev && RST_NI)
        chk("req_hold", {REQ_VALID_O, REQ_WE_O, REQ_ADDR_O, REQ_WDATA_O}, {1'b1, req_prev});
      if (REQ_VALID_O && REQ_READY_I) begin
        checks++;
        assert (req_exp.size() != 0) else begin
          errors++;
          $error("FAIL req_unexpected observed=%0h expected=none", REQ_ADDR_O);
        end
        if (req_exp.size() != 0) begin
          e = req_exp.pop_front();
          chk("req_we", REQ_WE_O, e[40]);
          chk("req_addr", REQ_ADDR_O, e[39:32]);
          if (e[40]) chk("req_wdata", REQ_WDATA_O, e[31:0]);
        end
      end
      re_prev  = UART_RE_O;
      we_prev  = UART_WE_O;
      vld_prev = REQ_VALID_O;
      rdy_prev = REQ_READY_I;
      req_prev = {REQ_WE_O, REQ_ADDR_O, REQ_WDATA_O};
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_re"},    UART_RE_O, 1'b0);
    chk({tag, "_we"},    UART_WE_O, 1'b0);
    chk({tag, "_dsend"}, UART_DSEND_O, 8'h00);
    chk({tag, "_vld"},   REQ_VALID_O, 1'b0);
    chk({tag, "_rwe"},   REQ_WE_O, 1'b0);
    chk({tag, "_addr"},  REQ_ADDR_O, 8'h00);
    chk({tag, "_wdata"}, REQ_WDATA_O, 32'h0);
    chk({tag, "_busy"},  BUSY_O, 1'b0);
  endtask

  initial begin
    int cnt0;
    bit seen;
    RST_NI          = 1'b0;
    UART_TX_READY_I = 1'b1;
    REQ_READY_I     = 1'b1;
    cyc(3);
    chk_reset_outputs("rst");
    RST_NI = 1'b1;
    cyc(2);

    // WRITE 0x12345678 to 0x10
    rsp_delay = 1; rsp_err = 1'b0;
    req_exp.push_back({1'b1, 8'h10, 32'h12345678});
    tx_exp.push_back(8'h00);
    push_bytes('{8'h02, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12});
    wait_idle("write");

    // READ 0x20, response 5 cycles after handshake
    rsp_delay = 5; rsp_rdata = 32'hDEADBEEF;
    req_exp.push_back({1'b0, 8'h20, 32'h0});
    tx_exp.push_back(8'h00); tx_exp.push_back(8'hEF); tx_exp.push_back(8'hBE);
    tx_exp.push_back(8'hAD); tx_exp.push_back(8'hDE);
    push_bytes('{8'h01, 8'h20});
    wait_idle("read");

    // unknown command then PING, back to back
    tx_exp.push_back(8'hEE); tx_exp.push_back(8'h00);
    push_bytes('{8'h7F, 8'h03});
    wait_idle("unk_ping");

    // READ with error returns status only
    rsp_delay = 2; rsp_err = 1'b1; rsp_rdata = 32'h55AA55AA;
    req_exp.push_back({1'b0, 8'h30, 32'h0});
    tx_exp.push_back(8'h01);
    push_bytes('{8'h01, 8'h30});
    wait_idle("read_err");

    // request held for 20 cycles without ready
    rsp_err = 1'b0; rsp_delay = 1; rsp_rdata = 32'hCAFEF00D;
    REQ_READY_I = 1'b0;
    req_exp.push_back({1'b0, 8'h40, 32'h0});
    tx_exp.push_back(8'h00); tx_exp.push_back(8'h0D); tx_exp.push_back(8'hF0);
    tx_exp.push_back(8'hFE); tx_exp.push_back(8'hCA);
    push_bytes('{8'h01, 8'h40});
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      cyc(1);
      seen = REQ_VALID_O;
    end
    chk("hold_vld_seen", seen, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("hold_vld", REQ_VALID_O, 1'b1);
      chk("hold_addr", {REQ_WE_O, REQ_ADDR_O}, {1'b0, 8'h40});
    end
    REQ_READY_I = 1'b1;
    wait_idle("hold");

    // transmitter busy: no strobe until ready returns
    UART_TX_READY_I = 1'b0;
    tx_exp.push_back(8'h00);
    cnt0 = we_count;
    push_bytes('{8'h03});
    cyc(20);
    chk("txstall_nowe", we_count, cnt0);
    chk("txstall_busy", BUSY_O, 1'b1);
    UART_TX_READY_I = 1'b1;
    wait_idle("txstall");

`ifdef UART_CMD_BRIDGE_TIMEOUT_EN
    // partial WRITE dropped after the inter-byte timeout
    push_bytes('{8'h02, 8'h10});
    cyc(10);
    chk("tmo_busy_before", BUSY_O, 1'b1);
    cyc(60);
    chk("tmo_busy_after", BUSY_O, 1'b0);
    tx_exp.push_back(8'h00);
    push_bytes('{8'h03});
    wait_idle("tmo_ping");
`endif

    // reset in the middle of a WRITE data phase
    push_bytes('{8'h02, 8'h10, 8'h11, 8'h22});
    cyc(12);
    chk("mid_busy", BUSY_O, 1'b1);
    RST_NI = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    cyc(3);
    RST_NI = 1'b1;
    cyc(2);
    rsp_delay = 3; rsp_rdata = 32'h01020304;
    req_exp.push_back({1'b0, 8'h55, 32'h0});
    tx_exp.push_back(8'h00); tx_exp.push_back(8'h04); tx_exp.push_back(8'h03);
    tx_exp.push_back(8'h02); tx_exp.push_back(8'h01);
    push_bytes('{8'h01, 8'h55});
    wait_idle("post_rst_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
